// File: rtl/pc_stack_unit.sv
// Program counter with optional return-address stack for CALL/RET.
// Define PC_CALL_STACK_EN to build the stack in; otherwise CALL acts as JMP, RET as INC.
module pc_stack_unit #(
    parameter int AW    = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [2:0]                 op,
    input  logic [AW-1:0]              target,
    input  logic [AW-1:0]              offset,
    input  logic                       err_clr,
    output logic [AW-1:0]              pc_out,
    output logic [$clog2(DEPTH):0]     sp_count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int SW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_JMP  = 3'b010,
        OP_BR   = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_t;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] stack_top;

    assign pc_inc = pc_out + AW'(1);
    assign empty  = (sp_count == '0);
    assign full   = (sp_count == SW'(DEPTH));

    // Two's-complement offset: plain modular addition gives the signed result.
    always_comb begin
        pc_next = pc_out;
        case (op_t'(op))
            OP_INC:  pc_next = pc_inc;
            OP_JMP:  pc_next = target;
            OP_BR:   pc_next = pc_out + offset;
            OP_CALL: pc_next = target;
`ifdef PC_CALL_STACK_EN
            OP_RET:  pc_next = empty ? pc_inc : stack_top;
`else
            OP_RET:  pc_next = pc_inc;
`endif
            default: pc_next = pc_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out <= '0;
        end else if (en) begin
            pc_out <= pc_next;
        end
    end

`ifdef PC_CALL_STACK_EN
    logic [AW-1:0] stack_mem [DEPTH];
    logic [SW-1:0] sp_dec;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          unf_set;

    assign sp_dec    = sp_count - SW'(1);
    assign stack_top = stack_mem[sp_dec[IW-1:0]];
    assign push      = en && (op == OP_CALL) && !full;
    assign pop       = en && (op == OP_RET) && !empty;
    assign ovf_set   = en && (op == OP_CALL) && full;
    assign unf_set   = en && (op == OP_RET) && empty;

    // Storage is not reset; entries at or above sp_count are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[sp_count[IW-1:0]] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_count <= '0;
        end else if (push) begin
            sp_count <= sp_count + SW'(1);
        end else if (pop) begin
            sp_count <= sp_dec;
        end
    end

    // A new error in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (unf_set) begin
                unf_err <= 1'b1;
            end else if (err_clr) begin
                unf_err <= 1'b0;
            end
        end
    end
`else
    logic unused_inputs;

    assign stack_top     = '0;
    assign sp_count      = '0;
    assign ovf_err       = 1'b0;
    assign unf_err       = 1'b0;
    assign unused_inputs = &{1'b0, err_clr, stack_top};
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus random stimulus vs. a queue-based model.
module tb_pc_stack_unit;

    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int SW    = $clog2(DEPTH) + 1;
    localparam int MOD   = 1 << AW;

    localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JMP = 3'b010, BR = 3'b011,
                           CALL = 3'b100, RET = 3'b101;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic [2:0]      op = HOLD;
    logic [AW-1:0]   target = '0;
    logic [AW-1:0]   offset = '0;
    logic            err_clr = 1'b0;
    logic [AW-1:0]   pc_out;
    logic [SW-1:0]   sp_count;
    logic            empty, full, ovf_err, unf_err;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_pc = 0;
    int m_stk[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    pc_stack_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .target(target), .offset(offset),
        .err_clr(err_clr), .pc_out(pc_out), .sp_count(sp_count), .empty(empty),
        .full(full), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    function automatic void model_step(bit r, bit e, logic [2:0] o, int t, int off, bit c);
        bit new_ovf = 0;
        bit new_unf = 0;
        int soff;
        if (r) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        if (e) begin
            case (o)
                INC: m_pc = (m_pc + 1) % MOD;
                JMP: m_pc = t;
                BR: begin
                    soff = (off >= MOD / 2) ? off - MOD : off;
                    m_pc = ((m_pc + soff) % MOD + MOD) % MOD;
                end
                CALL: begin
`ifdef PC_CALL_STACK_EN
                    if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % MOD);
                    else new_ovf = 1;
`endif
                    m_pc = t;
                end
                RET: begin
`ifdef PC_CALL_STACK_EN
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        m_pc = (m_pc + 1) % MOD;
                        new_unf = 1;
                    end
`else
                    m_pc = (m_pc + 1) % MOD;
`endif
                end
                default: ;
            endcase
        end
        if (c) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (new_ovf) m_ovf = 1;
        if (new_unf) m_unf = 1;
    endfunction

    // Apply one cycle of stimulus, advance the model, and sample 1ns after the edge.
    task automatic drive(input bit r, input bit e, input logic [2:0] o,
                         input logic [AW-1:0] t, input logic [AW-1:0] off, input bit c);
        reset = r; en = e; op = o; target = t; offset = off; err_clr = c;
        @(posedge clk);
        model_step(r, e, o, int'(t), int'(off), c);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, RET, 10'h155, 10'h0AA, 0);
        drive(1, 1, CALL, 10'h2AA, 10'h000, 0);
        checks++;
        if (pc_out !== '0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
        checks++;
        if (sp_count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL reset_sp got sp=%0d empty=%b full=%b exp sp=0 empty=1 full=0",
                               sp_count, empty, full);
        end
        checks++;
        if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0 0", ovf_err, unf_err);
        end
    endtask

    task automatic test_inc_wrap();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, INC, '0, '0, 0);
            checks++;
            if (pc_out !== AW'(i)) begin errors++; $display("FAIL inc_step got=%h exp=%h", pc_out, AW'(i)); end
        end
        drive(0, 1, JMP, 10'h3FF, '0, 0);
        checks++;
        if (pc_out !== 10'h3FF) begin errors++; $display("FAIL jmp got=%h exp=3ff", pc_out); end
        drive(0, 1, INC, '0, '0, 0);
        checks++;
        if (pc_out !== 10'h000) begin errors++; $display("FAIL inc_wrap got=%h exp=000", pc_out); end
    endtask

    task automatic test_branch_hold();
        drive(0, 1, JMP, 10'h100, '0, 0);
        drive(0, 1, BR, '0, 10'h3FC, 0);
        checks++;
        if (pc_out !== 10'h0FC) begin errors++; $display("FAIL br_neg got=%h exp=0fc", pc_out); end
        drive(0, 1, BR, '0, 10'h010, 0);
        checks++;
        if (pc_out !== 10'h10C) begin errors++; $display("FAIL br_pos got=%h exp=10c", pc_out); end
        drive(0, 0, JMP, 10'h2FF, '0, 0);
        checks++;
        if (pc_out !== 10'h10C) begin errors++; $display("FAIL en_hold got=%h exp=10c", pc_out); end
        drive(0, 1, 3'b110, 10'h2FF, 10'h001, 0);
        drive(0, 1, 3'b111, 10'h2FF, 10'h001, 0);
        drive(0, 1, HOLD, 10'h2FF, 10'h001, 0);
        checks++;
        if (pc_out !== 10'h10C || sp_count !== '0) begin
            errors++; $display("FAIL reserved_hold got pc=%h sp=%0d exp pc=10c sp=0", pc_out, sp_count);
        end
    endtask

    task automatic test_nested_call();
        logic [2:0]    ops[6] = '{JMP, CALL, JMP, CALL, RET, RET};
        logic [AW-1:0] tgt[6] = '{10'h010, 10'h200, 10'h205, 10'h300, 10'h000, 10'h000};
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, ops[i], tgt[i], '0, 0);
            checks++;
            if (pc_out !== AW'(m_pc) || sp_count !== SW'(m_stk.size())) begin
                errors++; $display("FAIL nested_step%0d got pc=%h sp=%0d exp pc=%h sp=%0d",
                                   i, pc_out, sp_count, AW'(m_pc), m_stk.size());
            end
`ifdef PC_CALL_STACK_EN
            if (i == 4) begin
                checks++;
                if (pc_out !== 10'h206) begin errors++; $display("FAIL nested_ret1 got=%h exp=206", pc_out); end
            end
            if (i == 5) begin
                checks++;
                if (pc_out !== 10'h011) begin errors++; $display("FAIL nested_ret2 got=%h exp=011", pc_out); end
            end
`endif
        end
    endtask

    task automatic test_overflow_underflow();
        drive(1, 0, HOLD, '0, '0, 0);
        for (int i = 0; i <= DEPTH; i++) begin
            drive(0, 1, CALL, AW'(16 * i + 32), '0, 0);
            checks++;
            if (pc_out !== AW'(m_pc) || sp_count !== SW'(m_stk.size()) ||
                full !== (m_stk.size() == DEPTH) || ovf_err !== m_ovf) begin
                errors++; $display("FAIL call_fill%0d got pc=%h sp=%0d full=%b ovf=%b exp pc=%h sp=%0d ovf=%b",
                                   i, pc_out, sp_count, full, ovf_err, AW'(m_pc), m_stk.size(), m_ovf);
            end
        end
        for (int i = 0; i <= DEPTH; i++) begin
            drive(0, 1, RET, '0, '0, 0);
            checks++;
            if (pc_out !== AW'(m_pc) || sp_count !== SW'(m_stk.size()) ||
                empty !== (m_stk.size() == 0) || unf_err !== m_unf) begin
                errors++; $display("FAIL ret_drain%0d got pc=%h sp=%0d empty=%b unf=%b exp pc=%h sp=%0d unf=%b",
                                   i, pc_out, sp_count, empty, unf_err, AW'(m_pc), m_stk.size(), m_unf);
            end
        end
    endtask

    task automatic test_err_clr();
        logic [AW-1:0] held;
        drive(1, 0, HOLD, '0, '0, 0);
        for (int i = 0; i <= DEPTH; i++) drive(0, 1, CALL, AW'(i + 100), '0, 0);
        drive(0, 1, CALL, 10'h3A0, '0, 1);
        checks++;
        if (ovf_err !== m_ovf || pc_out !== AW'(m_pc)) begin
            errors++; $display("FAIL clr_vs_new got ovf=%b pc=%h exp ovf=%b pc=%h", ovf_err, pc_out, m_ovf, AW'(m_pc));
        end
        held = pc_out;
        drive(0, 0, CALL, 10'h001, '0, 1);
        checks++;
        if (ovf_err !== 1'b0 || unf_err !== 1'b0 || pc_out !== held || sp_count !== SW'(m_stk.size())) begin
            errors++; $display("FAIL clr_idle got ovf=%b unf=%b pc=%h sp=%0d exp 0 0 %h %0d",
                               ovf_err, unf_err, pc_out, sp_count, held, m_stk.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, CALL, 10'h050, '0, 0);
        drive(0, 1, CALL, 10'h060, '0, 0);
        drive(1, 1, RET, '0, '0, 0);
        checks++;
        if (pc_out !== '0 || sp_count !== '0 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_reset got pc=%h sp=%0d empty=%b exp 0 0 1", pc_out, sp_count, empty);
        end
        drive(0, 1, RET, '0, '0, 0);
        checks++;
        if (pc_out !== 10'h001 || unf_err !== m_unf) begin
            errors++; $display("FAIL ret_after_reset got pc=%h unf=%b exp pc=001 unf=%b", pc_out, unf_err, m_unf);
        end
    endtask

    task automatic test_random();
        logic [2:0] o;
        bit r, e, c;
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 9) == 0);
            // bias toward CALL/RET so the stack reaches both boundaries
            o = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : (($urandom_range(0, 1) != 0) ? CALL : RET);
            drive(r, e, o, AW'($urandom), AW'($urandom), c);
            checks++;
            if (pc_out !== AW'(m_pc) || sp_count !== SW'(m_stk.size()) || empty !== (m_stk.size() == 0) ||
                full !== (m_stk.size() == DEPTH) || ovf_err !== m_ovf || unf_err !== m_unf) begin
                errors++;
                $display("FAIL random%0d got pc=%h sp=%0d e=%b f=%b ovf=%b unf=%b exp pc=%h sp=%0d ovf=%b unf=%b",
                         n, pc_out, sp_count, empty, full, ovf_err, unf_err, AW'(m_pc), m_stk.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_wrap();
        test_branch_hold();
        test_nested_call();
        test_overflow_underflow();
        test_err_clr();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter AW, default 10: program-address width in bits.
REQ-002 Parameter DEPTH, default 8: return-stack entries; legal range 2..64.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  step enable; when low, all state holds.
REQ-006 op  input  3  operation: 000 HOLD, 001 INC, 010 JMP, 011 BR, 100 CALL, 101 RET, 110/111 reserved.
REQ-007 target  input  AW  absolute destination for JMP and CALL.
REQ-008 offset  input  AW  two's-complement displacement for BR.
REQ-009 err_clr  input  1  clears sticky error flags.
REQ-010 pc_out  output  AW  current program counter, registered.
REQ-011 sp_count  output  clog2(DEPTH)+1  number of valid stack entries, registered.
REQ-012 empty  output  1  high when sp_count==0.
REQ-013 full  output  1  high when sp_count==DEPTH.
REQ-014 ovf_err  output  1  sticky: CALL attempted while full.
REQ-015 unf_err  output  1  sticky: RET attempted while empty.

Function
REQ-016 All state SHALL update only on rising clk; every op takes effect in exactly 1 cycle, and pc_out reflects it on the following cycle.
REQ-017 With en=0, pc_out, stack contents, sp_count and error flags SHALL hold, except that err_clr SHALL still act.
REQ-018 HOLD and the reserved opcodes SHALL leave all state unchanged.
REQ-019 INC SHALL set pc_out to pc_out+1 modulo 2^AW, so the maximum value wraps to 0.
REQ-020 JMP SHALL set pc_out to target.
REQ-021 BR SHALL set pc_out to pc_out+offset modulo 2^AW, with offset treated as signed.
REQ-022 CALL when not full SHALL push (pc_out+1 mod 2^AW), increment sp_count, and set pc_out to target.
REQ-023 CALL when full SHALL set pc_out to target, leave the stack and sp_count unchanged, and set ovf_err.
REQ-024 RET when not empty SHALL set pc_out to the top entry and decrement sp_count.
REQ-025 RET when empty SHALL set pc_out to pc_out+1 and set unf_err, leaving sp_count at 0.
REQ-026 The stack SHALL be LIFO, and only entries below sp_count SHALL be observable through RET.
REQ-027 err_clr SHALL clear both error flags; if a new error occurs in the same cycle, the new error SHALL win and its flag SHALL read 1.
REQ-028 empty and full SHALL be combinational decodes of registered sp_count only.

Reset
REQ-029 reset SHALL take priority over en, op and err_clr.
REQ-030 On reset: pc_out=0, sp_count=0, empty=1, full=0, ovf_err=0, unf_err=0.
REQ-031 Stack storage contents SHALL be don't-care after reset.
REQ-032 A reset asserted mid-sequence (for example between CALL and RET) SHALL discard all stacked return addresses.

Configuration
REQ-033 Macro PC_CALL_STACK_EN SHALL compile the return stack in.
REQ-034 With PC_CALL_STACK_EN defined, behaviour SHALL follow REQ-022..REQ-027.
REQ-035 Without PC_CALL_STACK_EN, no stack storage SHALL exist and CALL SHALL behave as JMP.
REQ-036 Without PC_CALL_STACK_EN, RET SHALL behave as INC.
REQ-037 Without PC_CALL_STACK_EN, sp_count SHALL be tied to 0, empty to 1, full to 0, and ovf_err/unf_err to 0.

Verification
REQ-038 Reset, then en=1 with INC for 3 cycles -> pc_out 0,1,2,3; set pc_out=0x3FF via JMP, then INC -> pc_out=0x000.
REQ-039 pc_out=0x100, BR with offset=0x3FC (-4) -> pc_out=0x0FC; BR with offset=0x010 -> pc_out=0x10C.
REQ-040 Nested CALLs from pc 0x010->0x200 and 0x205->0x300, then RET, RET -> pc_out 0x206 then 0x011; sp_count 1,2,1,0.
REQ-041 DEPTH=8: 9 CALLs -> full=1 after the 8th; the 9th jumps and sets ovf_err with sp_count=8; 8 RETs return in LIFO order; a 9th RET sets unf_err and gives pc+1.
REQ-042 ovf_err=1 with err_clr and an overflowing CALL in the same cycle -> ovf_err stays 1; err_clr alone with en=0 -> flags cleared while pc_out holds.
REQ-043 After 2 CALLs, assert reset with op=RET -> pc_out=0, sp_count=0, empty=1; next RET -> unf_err=1, pc_out=1. Rerun with PC_CALL_STACK_EN undefined -> CALL acts as JMP, RET as INC, flags stay 0.
